w_update_bank: RTL

//  Multi-tap LMS weight-update engine for the HSAF adaptive filter. Keeps a TAPS-deep input delay line and TAPS weights.
//  On each accepted mu_error it sweeps taps serially through one shared multiplier: w[k] += rnd(x[k]*mu_error).

---
 rtl/hsaf_pkg.sv | 17 +
 rtl/w_tap_mac.sv | 45 ++++
 rtl/w_update_bank.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hsaf_pkg.sv
// Shared definitions for the HSAF adaptive filter weight-update path.
package hsaf_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_QP    = 12;

   // Saturation limits for the default word width.
   localparam logic [DEF_WIDTH-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [DEF_WIDTH-1:0] SAT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/w_tap_mac.sv
// Per-tap LMS datapath: w + rnd(x*mu) with round-half-up and saturation.
module w_tap_mac #(
   parameter int WIDTH = 16,
   parameter int QP    = 12
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] mu,
   input  logic [WIDTH-1:0] w,
   output logic [WIDTH-1:0] w_new,
   output logic             sat
);

   // One guard bit above the full product so the sum can never wrap.
   localparam int PW = 2*WIDTH + 1;
   localparam logic signed [PW-1:0] RND   = PW'(1) << (QP-1);
   localparam logic signed [PW-1:0] S_MAX = (PW'(1) << (WIDTH-1)) - PW'(1);
   localparam logic signed [PW-1:0] S_MIN = ~S_MAX;

   logic signed [PW-1:0] x_ext;
   logic signed [PW-1:0] mu_ext;
   logic signed [PW-1:0] w_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] delta;
   logic signed [PW-1:0] sum;

   // Multiply, round to QP, accumulate, clamp to the word range.
   always_comb begin
      x_ext  = $signed({{(WIDTH+1){x[WIDTH-1]}}, x});
      mu_ext = $signed({{(WIDTH+1){mu[WIDTH-1]}}, mu});
      w_ext  = $signed({{(WIDTH+1){w[WIDTH-1]}}, w});
      prod   = x_ext * mu_ext;
      delta  = (prod + RND) >>> QP;
      sum    = w_ext + delta;
      w_new  = sum[WIDTH-1:0];
      sat    = 1'b0;
      if (sum > S_MAX) begin
         w_new = S_MAX[WIDTH-1:0];
         sat   = 1'b1;
      end else if (sum < S_MIN) begin
         w_new = S_MIN[WIDTH-1:0];
         sat   = 1'b1;
      end
   end

endmodule

// File: rtl/w_update_bank.sv
// Multi-tap LMS weight-update engine: delay line, weight bank, serial tap sweep.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepts x samples, weight loads and mu_error
// ST_SWEEP | one tap per cycle through the shared MAC, line frozen
// ST_DONE  | one-cycle completion pulse, inputs still blocked
module w_update_bank
   import hsaf_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int QP        = DEF_QP,
   parameter int TAPS      = 8,
   parameter int IDXW      = 3,
   parameter int RESET_VAL = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      x_in,
   input  logic                  x_valid,
   output logic                  x_ready,
   input  logic [WIDTH-1:0]      mu_error,
   input  logic                  err_valid,
   output logic                  err_ready,
   input  logic                  freeze,
   input  logic                  w_load,
   input  logic [IDXW-1:0]       w_load_idx,
   input  logic [WIDTH-1:0]      w_load_data,
   output logic [TAPS*WIDTH-1:0] weights,
   output logic                  busy,
   output logic                  done,
   output logic                  sat_flag
);

   localparam logic [WIDTH-1:0] W_RST    = WIDTH'(RESET_VAL <<< QP);
   localparam logic [IDXW-1:0]  LAST_TAP = IDXW'(TAPS-1);

   state_e           state_q, state_d;
   logic [IDXW-1:0]  k_q, k_d;
   logic [WIDTH-1:0] mu_q, mu_d;
   logic             frz_q, frz_d;
   logic             sat_q, sat_d;
   logic [WIDTH-1:0] x_q [TAPS];
   logic [WIDTH-1:0] x_d [TAPS];
   logic [WIDTH-1:0] w_q [TAPS];
   logic [WIDTH-1:0] w_d [TAPS];

   logic [WIDTH-1:0] mac_mu;
   logic [WIDTH-1:0] mac_w;
   logic             mac_sat;

   // A frozen sweep runs with a zero step so timing is unchanged.
   assign mac_mu = frz_q ? '0 : mu_q;

   w_tap_mac #(
      .WIDTH (WIDTH),
      .QP    (QP)
   ) u_mac (
      .x     (x_q[k_q]),
      .mu    (mac_mu),
      .w     (w_q[k_q]),
      .w_new (mac_w),
      .sat   (mac_sat)
   );

   // Next-state logic for FSM, tap counter, delay line and weight bank.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      mu_d    = mu_q;
      frz_d   = frz_q;
      sat_d   = sat_q;
      x_d     = x_q;
      w_d     = w_q;
      case (state_q)
         ST_IDLE: begin
            if (x_valid) begin
               x_d[0] = x_in;
               for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
            end
            // Out-of-range indices (non power-of-two TAPS) are dropped.
            if (w_load && (int'(w_load_idx) < TAPS)) w_d[w_load_idx] = w_load_data;
            if (err_valid) begin
               mu_d    = mu_error;
               frz_d   = freeze;
               k_d     = '0;
               state_d = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            w_d[k_q] = mac_w;
            if (mac_sat) sat_d = 1'b1;
            if (k_q == LAST_TAP) state_d = ST_DONE;
            else                 k_d     = k_q + IDXW'(1);
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any sweep in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         mu_q    <= '0;
         frz_q   <= 1'b0;
         sat_q   <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            w_q[i] <= W_RST;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         mu_q    <= mu_d;
         frz_q   <= frz_d;
         sat_q   <= sat_d;
         x_q     <= x_d;
         w_q     <= w_d;
      end
   end

   // Flatten the weight bank onto the output bus, tap k at [k*WIDTH +: WIDTH].
   always_comb begin
      weights = '0;
      for (int i = 0; i < TAPS; i++) weights[i*WIDTH +: WIDTH] = w_q[i];
   end

   assign x_ready   = (state_q == ST_IDLE);
   assign err_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_SWEEP);
   assign done      = (state_q == ST_DONE);
   assign sat_flag  = sat_q;

endmodule
